// File: rtl/simon_pkg.sv
// Shared Simon types: FSM states, 2-bit color codes and the active-low LED encodings.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        WAIT_ACK,
        CAPTURE,
        REPLAY_PRESS,
        REPLAY_GAP
    } state_t;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'b00,
        COLOR_BLUE   = 2'b01,
        COLOR_YELLOW = 2'b10,
        COLOR_GREEN  = 2'b11
    } color_t;

    localparam logic [2:0] LED_RED     = 3'b011;
    localparam logic [2:0] LED_BLUE    = 3'b110;
    localparam logic [2:0] LED_YELLOW  = 3'b001;
    localparam logic [2:0] LED_GREEN   = 3'b101;
    localparam logic [2:0] LED_CYAN    = 3'b100;
    localparam logic [2:0] LED_MAGENTA = 3'b010;
    localparam logic [2:0] LED_WHITE   = 3'b000;
    localparam logic [2:0] LED_OFF     = 3'b111;

    function automatic color_t color_next(input color_t c);
        return color_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/led_color_decoder.sv
// Combinational decode of the game's active-low RGB LED into a color code and event flags.
module led_color_decoder
    import simon_pkg::*;
(
    input  logic [2:0] led_rgb,
    output color_t     color,
    output logic       is_color,
    output logic       is_ack,
    output logic       is_err,
    output logic       is_ok
);

    always_comb begin
        color    = COLOR_RED;
        is_color = 1'b0;
        is_ack   = 1'b0;
        is_err   = 1'b0;
        is_ok    = 1'b0;
        case (led_rgb)
            LED_RED:     begin color = COLOR_RED;    is_color = 1'b1; end
            LED_BLUE:    begin color = COLOR_BLUE;   is_color = 1'b1; end
            LED_YELLOW:  begin color = COLOR_YELLOW; is_color = 1'b1; end
            LED_GREEN:   begin color = COLOR_GREEN;  is_color = 1'b1; end
            LED_CYAN:    is_ack = 1'b1;
            LED_MAGENTA: is_err = 1'b1;
            LED_WHITE:   is_ok  = 1'b1;
            default:     ;
        endcase
    end

endmodule

// File: rtl/simon_autoplayer.sv
// Plays Simon automatically: kicks a game, captures each shown sequence from the LED,
// replays it on the buttons and reports the game's win/lose/protocol outcome.
module simon_autoplayer
    import simon_pkg::*;
#(
    parameter int COLOR_CYCLES = 101,
    parameter int GAP_CYCLES   = 4,
    parameter int MAX_LEN      = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       force_wrong,
    input  logic [2:0] led_rgb,
    output logic       iniciar_jogo,
    output logic       bot_vermelho,
    output logic       bot_azul,
    output logic       bot_amarelo,
    output logic       bot_verde,
    output logic [5:0] round_len,
    output logic       busy,
    output logic       done_ok,
    output logic       done_err,
    output logic       protocol_err
);

    localparam int SW = (COLOR_CYCLES > 1) ? $clog2(COLOR_CYCLES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(COLOR_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [5:0]    LEN_MAX   = 6'(MAX_LEN);

    state_t        state, state_nxt;
    logic [SW-1:0] slot, slot_nxt;
    logic [GW-1:0] gap, gap_nxt;
    logic [5:0]    idx, idx_nxt;
    logic [5:0]    len, len_nxt;
    logic          seen_ack, seen_ack_nxt;
    logic          force_lat, force_lat_nxt;
    logic          ok_q, ok_nxt, err_q, err_nxt, proto_q, proto_nxt;
    logic          wr_en, last, press;
    color_t        color, stored, press_code;
    logic          is_color, is_ack, is_err, is_ok;
    logic [1:0]    buffer [MAX_LEN];

    led_color_decoder u_dec (
        .led_rgb  (led_rgb),
        .color    (color),
        .is_color (is_color),
        .is_ack   (is_ack),
        .is_err   (is_err),
        .is_ok    (is_ok)
    );

    assign last       = (idx == len - 6'd1);
    assign stored     = color_t'(buffer[idx[IW-1:0]]);
    assign press_code = (force_lat && last) ? color_next(stored) : stored;

    always_comb begin
        state_nxt     = state;
        slot_nxt      = slot;
        gap_nxt       = gap;
        idx_nxt       = idx;
        len_nxt       = len;
        seen_ack_nxt  = seen_ack;
        force_lat_nxt = force_lat;
        ok_nxt        = 1'b0;
        err_nxt       = 1'b0;
        proto_nxt     = 1'b0;
        wr_en         = 1'b0;
        // Game verdicts override whatever the FSM was doing.
        if (state != IDLE && (is_err || is_ok)) begin
            state_nxt = IDLE;
            err_nxt   = is_err;
            ok_nxt    = is_ok;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_nxt   = 6'd1;
                    state_nxt = KICK;
                end
                KICK: begin
                    seen_ack_nxt = 1'b0;
                    state_nxt    = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (is_ack) begin
                        seen_ack_nxt = 1'b1;
                    end else if (seen_ack) begin
                        slot_nxt  = '0;
                        idx_nxt   = '0;
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    slot_nxt = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                    if (slot == '0) begin
                        if (!is_color) begin
                            proto_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            wr_en = 1'b1;
                            if (last) begin
                                idx_nxt       = '0;
                                force_lat_nxt = force_wrong;
                                state_nxt     = REPLAY_PRESS;
                            end else begin
                                idx_nxt = idx + 6'd1;
                            end
                        end
                    end
                end
                REPLAY_PRESS: begin
                    gap_nxt   = '0;
                    state_nxt = REPLAY_GAP;
                end
                REPLAY_GAP: begin
                    if (gap != GAP_LAST) begin
                        gap_nxt = gap + 1'b1;
                    end else if (!last) begin
                        idx_nxt   = idx + 6'd1;
                        state_nxt = REPLAY_PRESS;
                    end else begin
                        if (len != LEN_MAX) len_nxt = len + 6'd1;
                        seen_ack_nxt = 1'b0;
                        state_nxt    = WAIT_ACK;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            gap       <= '0;
            idx       <= '0;
            len       <= '0;
            seen_ack  <= 1'b0;
            force_lat <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            gap       <= gap_nxt;
            idx       <= idx_nxt;
            len       <= len_nxt;
            seen_ack  <= seen_ack_nxt;
            force_lat <= force_lat_nxt;
            ok_q      <= ok_nxt;
            err_q     <= err_nxt;
            proto_q   <= proto_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) buffer[idx[IW-1:0]] <= color;
    end

    // Outputs are masked by reset so they read zero for the whole reset window.
    assign press        = (state == REPLAY_PRESS) && !reset;
    assign iniciar_jogo = (state == KICK) && !reset;
    assign bot_vermelho = press && (press_code == COLOR_RED);
    assign bot_azul     = press && (press_code == COLOR_BLUE);
    assign bot_amarelo  = press && (press_code == COLOR_YELLOW);
    assign bot_verde    = press && (press_code == COLOR_GREEN);
    assign round_len    = reset ? 6'd0 : len;
    assign busy         = (state != IDLE) && !reset;
    assign done_ok      = ok_q && !reset;
    assign done_err     = err_q && !reset;
    assign protocol_err = proto_q && !reset;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer: kick/ack handshake, capture and replay of rounds,
// forced wrong press, verdict strobes, protocol error and reset during replay.
module tb_simon_autoplayer;

    logic       clock, reset, start, force_wrong;
    logic [2:0] led_rgb;
    logic       iniciar_jogo, bot_vermelho, bot_azul, bot_amarelo, bot_verde;
    logic [5:0] round_len;
    logic       busy, done_ok, done_err, protocol_err;

    int n_assert = 0;
    int n_fail   = 0;

    simon_autoplayer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .force_wrong  (force_wrong),
        .led_rgb      (led_rgb),
        .iniciar_jogo (iniciar_jogo),
        .bot_vermelho (bot_vermelho),
        .bot_azul     (bot_azul),
        .bot_amarelo  (bot_amarelo),
        .bot_verde    (bot_verde),
        .round_len    (round_len),
        .busy         (busy),
        .done_ok      (done_ok),
        .done_err     (done_err),
        .protocol_err (protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [3:0] btn;
    assign btn = {bot_vermelho, bot_azul, bot_amarelo, bot_verde};

    // Button monitor, sampled mid-cycle.
    int   cyc = 0, viol = 0;
    int   n_red = 0, n_blue = 0, n_yel = 0, n_grn = 0;
    int   last_press = 0, prev_press = 0;
    logic [3:0] last_btn = 4'b0;
    logic prev_any = 1'b0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            prev_any <= 1'b0;
        end else begin
            if ($countones(btn) > 1 || (|btn && prev_any)) viol <= viol + 1;
            if (bot_vermelho) n_red  <= n_red + 1;
            if (bot_azul)     n_blue <= n_blue + 1;
            if (bot_amarelo)  n_yel  <= n_yel + 1;
            if (bot_verde)    n_grn  <= n_grn + 1;
            if (|btn) begin
                prev_press <= last_press;
                last_press <= cyc;
                last_btn   <= btn;
            end
            prev_any <= |btn;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n, input logic [2:0] led);
        led_rgb = led;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    int b_red, b_blue, b_yel, b_grn;

    initial begin
        reset = 1'b1; start = 1'b0; force_wrong = 1'b0; led_rgb = 3'b111;
        tick(); tick(); tick();
        check("reset_outputs", {9'b0, iniciar_jogo, busy, btn, done_ok, done_err, protocol_err}, 16'h0);
        check("reset_round_len", 16'(round_len), 16'd0);

        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("kick_pulse", 16'(iniciar_jogo), 16'd1);
        check("kick_busy", 16'(busy), 16'd1);
        tick();
        check("kick_one_cycle", 16'(iniciar_jogo), 16'd0);
        check("first_round_len", 16'(round_len), 16'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy_ignored", 16'(iniciar_jogo), 16'd0);
        check("start_busy_len", 16'(round_len), 16'd1);

        // Round 1: single red entry.
        b_red = n_red; b_blue = n_blue; b_yel = n_yel; b_grn = n_grn;
        ticks(50, 3'b100);
        ticks(101, 3'b011);
        check("r1_red_presses", 16'(n_red - b_red), 16'd1);
        check("r1_other_presses", 16'((n_blue - b_blue) + (n_yel - b_yel) + (n_grn - b_grn)), 16'd0);
        check("r1_round_len", 16'(round_len), 16'd2);
        check("r1_busy", 16'(busy), 16'd1);

        // Round 2: blue, blue.
        b_blue = n_blue;
        ticks(10, 3'b100);
        ticks(202, 3'b110);
        check("r2_blue_presses", 16'(n_blue - b_blue), 16'd2);
        check("r2_press_spacing", 16'(last_press - prev_press), 16'd5);
        check("r2_round_len", 16'(round_len), 16'd3);

        // Round 3: yellow, yellow, green with the last press forced wrong.
        b_red = n_red; b_yel = n_yel; b_grn = n_grn;
        force_wrong = 1'b1;
        ticks(10, 3'b100);
        ticks(150, 3'b001);
        ticks(100, 3'b101);
        force_wrong = 1'b0;
        check("r3_yellow_presses", 16'(n_yel - b_yel), 16'd2);
        check("r3_forced_red", 16'(n_red - b_red), 16'd1);
        check("r3_no_green", 16'(n_grn - b_grn), 16'd0);
        check("r3_last_button", 16'(last_btn), 16'b1000);
        check("r3_round_len", 16'(round_len), 16'd4);

        // LED off where a color is sampled.
        ticks(3, 3'b100);
        ticks(2, 3'b111);
        check("proto_err_pulse", 16'(protocol_err), 16'd1);
        check("proto_err_idle", 16'(busy), 16'd0);
        tick();
        check("proto_err_one_cycle", 16'(protocol_err), 16'd0);

        // Magenta during the replay gap.
        kick_game();
        ticks(1, 3'b100);
        ticks(2, 3'b011);
        check("mag_press_red", 16'(btn), 16'b1000);
        tick();
        check("mag_gap_buttons", 16'(btn), 16'b0000);
        ticks(1, 3'b010);
        check("done_err_pulse", 16'(done_err), 16'd1);
        check("done_err_state", {12'b0, btn}, 16'h0);
        check("done_err_idle", 16'(busy), 16'd0);
        ticks(1, 3'b111);
        check("done_err_one_cycle", 16'(done_err), 16'd0);

        // White while waiting for the ack.
        kick_game();
        ticks(1, 3'b000);
        check("done_ok_pulse", 16'(done_ok), 16'd1);
        check("done_ok_idle", 16'(busy), 16'd0);
        ticks(1, 3'b111);
        check("done_ok_one_cycle", 16'(done_ok), 16'd0);

        // Reset while a button is asserted.
        kick_game();
        ticks(1, 3'b100);
        ticks(2, 3'b101);
        check("rst_press_green", 16'(btn), 16'b0001);
        reset = 1'b1;
        tick();
        check("rst_outputs", {9'b0, iniciar_jogo, busy, btn, done_ok, done_err, protocol_err}, 16'h0);
        check("rst_round_len", 16'(round_len), 16'd0);
        reset = 1'b0;
        ticks(2, 3'b111);

        check("button_exclusive_nonconsecutive", 16'(viol), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
